// File: rtl/window_pkg.sv
// Shared definitions for the window counter/accumulator stages.
// State encoding plus default widths kept common so both stages agree.
package window_pkg;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    ACCUM     = 1'b1
  } state_t;

  localparam int DEF_COUNT_WIDTH = 8;
  localparam int DEF_DROP_WIDTH  = 4;

endpackage

// File: rtl/window_accumulator_sat_incr.sv
// Saturating +1: holds at all-ones; sat_o flags an increment lost to saturation.
// Purely combinational, no backpressure.
module sat_incr #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] val_o,
  output logic             sat_o
);

  logic all_ones;

  assign all_ones = &val_i;
  assign sat_o    = inc_i & all_ones;
  assign val_o    = (inc_i && !all_ones) ? val_i + WIDTH'(1) : val_i;

endmodule

// File: rtl/window_accumulator.sv
// Counts sample-high cycles per tick-delimited window; result one cycle after the tick.
// Single-entry output register; windows offered while it is occupied are counted as drops.
module window_accumulator
  import window_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int DROP_WIDTH  = DEF_DROP_WIDTH
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   tick_in,
  input  logic                   sample_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_sat,
  output logic [DROP_WIDTH-1:0]  drop_count,
  output logic                   synced
);

  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] acc_q;
  logic                   acc_sat_q;
  logic                   out_valid_q;
  logic [COUNT_WIDTH-1:0] out_count_q;
  logic                   out_sat_q;
  logic [DROP_WIDTH-1:0]  drop_q;
  logic                   synced_q;

  logic [COUNT_WIDTH-1:0] window_total;
  logic                   acc_carry;
  logic                   total_sat;
  logic                   offer;
  logic                   out_free;
  logic                   drop_inc;
  logic [DROP_WIDTH-1:0]  drop_d;
  logic                   drop_at_max;

  sat_incr #(.WIDTH(COUNT_WIDTH)) u_acc_incr (
    .val_i (acc_q),
    .inc_i (sample_in),
    .val_o (window_total),
    .sat_o (acc_carry)
  );

  sat_incr #(.WIDTH(DROP_WIDTH)) u_drop_incr (
    .val_i (drop_q),
    .inc_i (drop_inc),
    .val_o (drop_d),
    .sat_o (drop_at_max)
  );

  assign total_sat = acc_sat_q | acc_carry;
  assign offer     = (state_q == ACCUM) & tick_in;
  // An accept in the same cycle frees the register for a new window.
  assign out_free  = ~out_valid_q | out_ready;
  assign drop_inc  = offer & ~out_free;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_SYNC;
      acc_q       <= '0;
      acc_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
      drop_q      <= '0;
      synced_q    <= 1'b0;
    end else begin
      case (state_q)
        WAIT_SYNC: begin
          if (tick_in) begin
            state_q  <= ACCUM;
            synced_q <= 1'b1;
          end
        end
        ACCUM: begin
          if (tick_in) begin
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
          end else begin
            acc_q     <= window_total;
            acc_sat_q <= total_sat;
          end
        end
      endcase

      if (offer && out_free) begin
        out_valid_q <= 1'b1;
        out_count_q <= window_total;
        out_sat_q   <= total_sat;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (drop_inc && !drop_at_max) begin
        drop_q <= drop_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_count  = out_count_q;
  assign out_sat    = out_sat_q;
  assign drop_count = drop_q;
  assign synced     = synced_q;

endmodule

// File: tb/tb_window_accumulator.sv
// Bench for window_accumulator: default-width instance scoreboarded on accepts,
// small-width instance exercised for count and drop saturation.
module tb_window_accumulator;

  logic       clk;
  logic       rst;
  logic       tick_a, sample_a, ready_a;
  logic       valid_a, sat_a, synced_a;
  logic [7:0] count_a;
  logic [3:0] drop_a;
  logic       tick_b, sample_b, ready_b;
  logic       valid_b, sat_b, synced_b;
  logic [3:0] count_b;
  logic [1:0] drop_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int count;
    int sat;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int len;
    int ones;
    int exp_count;
    int exp_sat;
  } win_t;
  win_t tbl[7];

  window_accumulator #(.COUNT_WIDTH(8), .DROP_WIDTH(4)) u_dut_a (
    .sys_clk    (clk),
    .rst        (rst),
    .tick_in    (tick_a),
    .sample_in  (sample_a),
    .out_ready  (ready_a),
    .out_valid  (valid_a),
    .out_count  (count_a),
    .out_sat    (sat_a),
    .drop_count (drop_a),
    .synced     (synced_a)
  );

  window_accumulator #(.COUNT_WIDTH(4), .DROP_WIDTH(2)) u_dut_b (
    .sys_clk    (clk),
    .rst        (rst),
    .tick_in    (tick_b),
    .sample_in  (sample_b),
    .out_ready  (ready_b),
    .out_valid  (valid_b),
    .out_count  (count_b),
    .out_sat    (sat_b),
    .drop_count (drop_b),
    .synced     (synced_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accepted outputs of instance A are compared against the queue in order.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && valid_a && ready_a) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got count %0d with no expected window", count_a);
      end else begin
        e = sb_q.pop_front();
        if (count_a != e.count[7:0] || sat_a != e.sat[0]) begin
          errors++;
          $display("FAIL sb_window: got count %0d sat %0d expected count %0d sat %0d",
                   count_a, sat_a, e.count, e.sat);
        end
      end
    end
  end

  task automatic push(input int c, input int s);
    exp_t e;
    e.count = c;
    e.sat   = s;
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit sel, input bit t, input bit s);
    if (sel) begin tick_b = t; sample_b = s; end
    else     begin tick_a = t; sample_a = s; end
    @(posedge clk);
    #1;
    if (sel) begin tick_b = 1'b0; sample_b = 1'b0; end
    else     begin tick_a = 1'b0; sample_a = 1'b0; end
  endtask

  // Window of len cycles ending in a tick; the last 'ones' cycles have sample high.
  task automatic run_window(input bit sel, input int len, input int ones);
    for (int i = 0; i < len; i++) drive(sel, (i == len - 1), (i >= len - ones));
  endtask

  initial begin
    tbl[0] = '{len: 5,   ones: 3,   exp_count: 3,   exp_sat: 0};
    tbl[1] = '{len: 1,   ones: 1,   exp_count: 1,   exp_sat: 0};
    tbl[2] = '{len: 1,   ones: 0,   exp_count: 0,   exp_sat: 0};
    tbl[3] = '{len: 12,  ones: 0,   exp_count: 0,   exp_sat: 0};
    tbl[4] = '{len: 10,  ones: 7,   exp_count: 7,   exp_sat: 0};
    tbl[5] = '{len: 300, ones: 300, exp_count: 255, exp_sat: 1};
    tbl[6] = '{len: 4,   ones: 4,   exp_count: 4,   exp_sat: 0};

    rst = 1'b1;
    tick_a = 0; sample_a = 0; ready_a = 1;
    tick_b = 0; sample_b = 0; ready_b = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_sat", sat_a, 0);
    chk("rst_drop", drop_a, 0);
    chk("rst_synced", synced_a, 0);
    rst = 1'b0;
    drive(0, 0, 1);

    // First tick only synchronises; second gives a full 9-cycle window.
    run_window(0, 9, 9);
    chk("sync_no_output", valid_a, 0);
    chk("sync_synced", synced_a, 1);
    push(9, 0);
    run_window(0, 9, 9);
    chk("first_window_valid", valid_a, 1);
    chk("first_window_count", count_a, 9);

    push(3, 0);
    run_window(0, 5, 3);
    chk("one_cycle_valid_hi", valid_a, 1);
    drive(0, 0, 0);
    chk("one_cycle_valid_lo", valid_a, 0);

    for (int i = 0; i < 7; i++) begin
      push(tbl[i].exp_count, tbl[i].exp_sat);
      run_window(0, tbl[i].len, tbl[i].ones);
    end
    drive(0, 0, 0);

    // Backpressure: first window held, next two dropped.
    ready_a = 1'b0;
    push(5, 0);
    run_window(0, 6, 5);
    run_window(0, 8, 7);
    run_window(0, 3, 2);
    chk("bp_valid", valid_a, 1);
    chk("bp_count_stable", count_a, 5);
    chk("bp_drop", drop_a, 2);
    ready_a = 1'b1;
    drive(0, 0, 0);
    chk("bp_release_valid", valid_a, 0);

    // Narrow instance: count saturation, then sticky flag cleared next window.
    run_window(1, 1, 0);
    chk("b_synced", synced_b, 1);
    run_window(1, 20, 20);
    chk("b_sat_valid", valid_b, 1);
    chk("b_sat_count", count_b, 15);
    chk("b_sat_flag", sat_b, 1);
    run_window(1, 4, 4);
    chk("b_next_count", count_b, 4);
    chk("b_next_flag", sat_b, 0);
    drive(1, 0, 0);

    ready_b = 1'b0;
    run_window(1, 3, 3);
    for (int i = 0; i < 6; i++) run_window(1, 2, 1);
    chk("b_drop_sat", drop_b, 3);
    chk("b_drop_hold_count", count_b, 3);
    chk("b_drop_hold_valid", valid_b, 1);
    ready_b = 1'b1;
    drive(1, 0, 0);
    chk("b_release_valid", valid_b, 0);

    // Reset in the middle of a window with accumulator at 4.
    for (int i = 0; i < 4; i++) drive(0, 0, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_count", count_a, 0);
    chk("mid_rst_sat", sat_a, 0);
    chk("mid_rst_drop", drop_a, 0);
    chk("mid_rst_synced", synced_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_window(0, 5, 5);
    chk("post_rst_no_output", valid_a, 0);
    chk("post_rst_synced", synced_a, 1);
    push(2, 0);
    run_window(0, 4, 2);
    chk("post_rst_window_valid", valid_a, 1);
    drive(0, 0, 0);
    drive(0, 0, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_accumulator.md
Name: window_accumulator

Overview:
Downstream consumer of the counter/AND stage. It takes the periodic window tick (counter_done) and the 1-bit sample (c_out). It counts sample-high cycles per tick-delimited window. Each completed window count is presented on a valid/ready output with a sticky saturation flag, and windows lost to output backpressure are counted.

Parameters:
COUNT_WIDTH, 8, width of the per-window sample count and the output count.
DROP_WIDTH, 4, width of the saturating dropped-window counter.

Ports:
sys_clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
tick_in  in  1  window-boundary pulse; the cycle with tick_in=1 is the last cycle of a window.
sample_in  in  1  sample to count; counted in every cycle where it is 1 and the FSM is in ACCUM.
out_ready  in  1  consumer accepts the output this cycle.
out_valid  out  1  out_count/out_sat hold a completed window.
out_count  out  COUNT_WIDTH  number of sample-high cycles in the window.
out_sat  out  1  the window count saturated at all-ones.
drop_count  out  DROP_WIDTH  windows discarded because the output was occupied; saturates at all-ones.
synced  out  1  FSM is in ACCUM (first tick has been seen).

Behaviour:
- Reset (async, rst=1): FSM=WAIT_SYNC, accumulator=0, acc_sat=0, out_valid=0, out_count=0, out_sat=0, drop_count=0, synced=0.
- FSM state WAIT_SYNC:
  - sample_in is ignored.
  - On tick_in=1, go to ACCUM. No output is produced. This aligns the block to window starts.
- FSM state ACCUM:
  - Each cycle, window_total = accumulator + sample_in, saturating at 2^COUNT_WIDTH-1.
  - total_sat = acc_sat OR (accumulator is all-ones AND sample_in=1).
  - tick_in=0: accumulator <= window_total; acc_sat <= total_sat.
  - tick_in=1: the tick cycle's sample is included in the window. Offer window_total/total_sat to the output register. Then accumulator <= 0 and acc_sat <= 0.
  - ACCUM has no exit except reset.
- Output register (single-entry):
  - It is free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle (pass-through accept).
  - Offer while free: next cycle out_valid=1, out_count=window_total, out_sat=total_sat.
  - Offer while not free: the held output is unchanged and drop_count increments by one, saturating.
  - No offer, and out_valid=1 with out_ready=1: out_valid <= 0 next cycle.
  - While out_valid=1 and out_ready=0, out_count and out_sat are stable.
  - out_ready has no effect while out_valid=0.
- Latency: out_valid rises one cycle after the tick cycle.
- synced = (state==ACCUM), registered.
- tick_in on consecutive cycles: each tick cycle is treated as a one-cycle window.
- Reset mid-window discards the partial count and returns the FSM to WAIT_SYNC.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package window_pkg:
  - FSM state encoding constants WAIT_SYNC=0, ACCUM=1.
  - Default COUNT_WIDTH and DROP_WIDTH constants, shared with the counter stage so window length and count width stay consistent.
- One natural sub-module: sat_incr (parameterised width, saturating +1 with carry-out flag), instantiated for the accumulator and for drop_count.

Test Plan:
- Reset, then sample_in=1 held and tick_in pulsed every 9 cycles -> first tick gives no output and synced=1; second tick gives out_valid=1, out_count=9, out_sat=0 one cycle later.
- In ACCUM, sample_in=1 on 3 cycles including the tick cycle, out_ready=1 -> out_count=3, out_valid high for exactly one cycle.
- out_ready=0 across three ticks with per-window counts 5, 7, 2 -> out_count stays 5; drop_count=2; after out_ready=1, out_valid clears the next cycle.
- COUNT_WIDTH=4, sample_in=1 for 20 cycles before the tick -> out_count=15, out_sat=1; the next window of 4 highs -> out_count=4, out_sat=0.
- DROP_WIDTH=2, out_ready=0 for 6 ticks after the first output -> drop_count saturates at 3.
- Assert rst mid-window with accumulator=4 -> all outputs 0 immediately and synced=0; the next tick gives no output.
